// File: rtl/exec_pkg.sv
// exec_pkg: opcode/state encodings, multiplier latency and single-cycle ALU helper
package exec_pkg;
  localparam int MUL_CYCLES = 8;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_MUL, OP_CMP} op_e;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_WB} state_e;
  // returns {flag, result}; SHL here covers only the zero-length shift
  function automatic logic [8:0] alu_f(input op_e op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {a < b, a - b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_CMP:  return {a < b, a};
      default: return {1'b0, a};
    endcase
  endfunction
endpackage

// File: rtl/exec_mul.sv
// exec_mul: iterative shift-add 8x8 multiplier; bit 0 is consumed on the load edge,
// so the product is stable after the 8th edge counting the start edge
module exec_mul (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_lo,
  output logic       o_hi_nz
);
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_acc    <= i_b[0] ? {8'b0, i_a} : 16'b0;
      r_mcand  <= {7'b0, i_a, 1'b0};
      r_mplier <= {1'b0, i_b[7:1]};
    end else begin
      r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 16'b0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end
  assign o_lo    = r_acc[7:0];
  assign o_hi_nz = |r_acc[15:8];
endmodule

// File: rtl/exec_unit.sv
// exec_unit: 8-bit execute stage with single-cycle ALU ops, bit-serial SHL and
// iterative MUL, writing back through a registered register-file port
module exec_unit
  import exec_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [7:0] rdVal,
  input  logic [7:0] rsVal,
  input  logic [2:0] rdAddrIn,
  output logic       writeEn,
  output logic [2:0] dest,
  output logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       flag
);
  state_e      r_state;
  logic [7:0]  r_sh;
  logic [2:0]  r_dst;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic        r_done;
  logic        r_flag;
  logic [7:0]  r_data;
  logic [2:0]  r_dest;
  op_e         w_op;
  state_e      w_next;
  logic        w_idle;
  logic        w_accept;
  logic        w_go;
  logic        w_wr;
  logic        w_flg;
  logic        w_mul_hz;
  logic [7:0]  w_res;
  logic [7:0]  w_shl;
  logic [7:0]  w_mul_lo;
  logic [8:0]  w_alu;
  exec_mul u_mul (
    .clk(clk), .rst(reset), .i_start(w_accept), .i_a(rdVal), .i_b(rsVal),
    .o_lo(w_mul_lo), .o_hi_nz(w_mul_hz)
  );
  // w_go marks the edge that enters WB, whichever path the operation took
  always_comb begin
    w_op     = op_e'(opcode);
    w_idle   = r_state == S_IDLE;
    w_accept = w_idle && start;
    w_alu    = alu_f(w_op, rdVal, rsVal);
    w_shl    = {r_sh[6:0], 1'b0};
    w_go     = (w_accept && w_op != OP_MUL && !(w_op == OP_SHL && rsVal[2:0] != 3'd0))
            || (r_state == S_SHIFT && r_cnt == 3'd1)
            || (r_state == S_MUL && r_cnt == 3'd0);
    w_wr     = !(w_idle && w_op == OP_CMP);
    w_res    = r_state == S_SHIFT ? w_shl : r_state == S_MUL ? w_mul_lo : w_alu[7:0];
    w_flg    = r_state == S_SHIFT ? r_sh[7] : r_state == S_MUL ? w_mul_hz : w_alu[8];
    w_next   = w_go ? S_WB
             : w_accept ? (w_op == OP_MUL ? S_MUL : S_SHIFT)
             : r_state == S_WB ? S_IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_flag  <= 1'b0;
      r_data  <= '0;
      r_dest  <= '0;
    end else begin
      r_state <= w_next;
      r_sh    <= w_idle ? rdVal : w_shl;
      r_dst   <= w_accept ? rdAddrIn : r_dst;
      r_cnt   <= w_accept ? (w_op == OP_MUL ? 3'(MUL_CYCLES - 1) : rsVal[2:0]) : r_cnt - 3'd1;
      r_we    <= w_go && w_wr;
      r_done  <= w_go;
      if (w_go) r_flag <= w_flg;
      if (w_go && w_wr) begin
        r_data <= w_res;
        r_dest <= w_idle ? rdAddrIn : r_dst;
      end
    end
  end
  assign writeEn = r_we;
  assign dest    = r_dest;
  assign data    = r_data;
  assign busy    = r_state != S_IDLE;
  assign done    = r_done;
  assign flag    = r_flag;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: vector table plus scoreboard queue, with hand sequences for abort and back-to-back starts
module tb_exec_unit;
  import exec_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = '0;
  logic [7:0] rdVal = '0;
  logic [7:0] rsVal = '0;
  logic [2:0] rdAddrIn = '0;
  logic       writeEn;
  logic [2:0] dest;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic       flag;
  always #5 clk = ~clk;
  exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .rdVal(rdVal), .rsVal(rsVal),
    .rdAddrIn(rdAddrIn), .writeEn(writeEn), .dest(dest), .data(data), .busy(busy),
    .done(done), .flag(flag)
  );
  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] adr;
    logic       we;
    logic [2:0] dst;
    logic [7:0] dat;
    logic       flg;
    int         lat;
  } vec_t;
  typedef struct {
    logic       we;
    logic [2:0] dst;
    logic [7:0] dat;
    logic       flg;
    int         lat;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] dq[$];
  vec_t       vt[16];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cur = -1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL [%0d] %s: got %0h expected %0h", cur, nm, act, exp);
  endtask
  // drive one op, scramble inputs after E0, then wait (bounded) for done
  task automatic run(input vec_t v);
    exp_t e;
    int   lat;
    bit   seen_we;
    seen_we = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = v.op; rdVal = v.a; rsVal = v.b; rdAddrIn = v.adr;
    e.we = v.we; e.dst = v.dst; e.dat = v.dat; e.flg = v.flg; e.lat = v.lat;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; rdVal = ~v.a; rsVal = ~v.b; rdAddrIn = ~v.adr; opcode = v.op ^ 3'd1;
    lat = 0;
    while (!done && lat < 20) begin
      if (writeEn) seen_we = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk("done_seen", done, 1);
    chk("latency", lat, e.lat);
    chk("early_we", seen_we, 0);
    chk("writeEn", writeEn, e.we);
    chk("dest", dest, e.dst);
    chk("data", data, e.dat);
    chk("flag", flag, e.flg);
    chk("busy_wb", busy, 1);
    @(posedge clk); #1;
    chk("done_end", done, 0);
    chk("we_end", writeEn, 0);
    chk("busy_end", busy, 0);
    chk("flag_hold", flag, e.flg);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int evt;
    bit acc;
    vt[0]  = '{OP_ADD, 8'hF0, 8'h20, 3'd3, 1'b1, 3'd3, 8'h10, 1'b1, 0};
    vt[1]  = '{OP_SUB, 8'h05, 8'h07, 3'd1, 1'b1, 3'd1, 8'hFE, 1'b1, 0};
    vt[2]  = '{OP_SUB, 8'h07, 8'h05, 3'd2, 1'b1, 3'd2, 8'h02, 1'b0, 0};
    vt[3]  = '{OP_AND, 8'hF0, 8'h3C, 3'd2, 1'b1, 3'd2, 8'h30, 1'b0, 0};
    vt[4]  = '{OP_OR,  8'h0F, 8'h30, 3'd4, 1'b1, 3'd4, 8'h3F, 1'b0, 0};
    vt[5]  = '{OP_XOR, 8'hFF, 8'h0F, 3'd5, 1'b1, 3'd5, 8'hF0, 1'b0, 0};
    vt[6]  = '{OP_ADD, 8'hFF, 8'h01, 3'd6, 1'b1, 3'd6, 8'h00, 1'b1, 0};
    vt[7]  = '{OP_SHL, 8'h81, 8'h03, 3'd6, 1'b1, 3'd6, 8'h08, 1'b0, 3};
    vt[8]  = '{OP_SHL, 8'h81, 8'h00, 3'd7, 1'b1, 3'd7, 8'h81, 1'b0, 0};
    vt[9]  = '{OP_SHL, 8'hC0, 8'h02, 3'd0, 1'b1, 3'd0, 8'h00, 1'b1, 2};
    vt[10] = '{OP_SHL, 8'h01, 8'hFF, 3'd1, 1'b1, 3'd1, 8'h80, 1'b0, 7};
    vt[11] = '{OP_MUL, 8'h12, 8'h10, 3'd0, 1'b1, 3'd0, 8'h20, 1'b1, 8};
    vt[12] = '{OP_MUL, 8'hFF, 8'hFF, 3'd3, 1'b1, 3'd3, 8'h01, 1'b1, 8};
    vt[13] = '{OP_MUL, 8'h05, 8'h03, 3'd1, 1'b1, 3'd1, 8'h0F, 1'b0, 8};
    vt[14] = '{OP_CMP, 8'h02, 8'h05, 3'd2, 1'b0, 3'd1, 8'h0F, 1'b1, 0};
    vt[15] = '{OP_CMP, 8'h05, 8'h02, 3'd4, 1'b0, 3'd1, 8'h0F, 1'b0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", writeEn, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flag", flag, 0);
    chk("rst_data", data, 0);
    chk("rst_dest", dest, 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cur = i;
      run(vt[i]);
    end
    cur = 100;
    @(negedge clk);
    reset = 1'b1; start = 1'b1; opcode = OP_ADD; rdVal = 8'h01; rsVal = 8'h01; rdAddrIn = 3'd2;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_done", done, 0);
    cur = 101;
    evt = 0;
    run(vt[13]);
    cur = 102;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = (c == 0 || c == 3);
      opcode = (c == 0) ? OP_MUL : OP_ADD;
      rdVal = 8'h12; rsVal = 8'h10; rdAddrIn = 3'd5;
      reset = (c == 5);
      @(posedge clk); #1;
      if (writeEn || done) evt++;
      if (c == 4) chk("abort_busy_pre", busy, 1);
    end
    chk("abort_events", evt, 0);
    chk("abort_we", writeEn, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_flag", flag, 0);
    chk("abort_data", data, 0);
    chk("abort_dest", dest, 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b1; opcode = OP_ADD; rdVal = 8'h01; rsVal = 8'h02; rdAddrIn = 3'd4;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_abort_done", done, 1);
    chk("post_abort_we", writeEn, 1);
    chk("post_abort_data", data, 8'h03);
    chk("post_abort_dest", dest, 3'd4);
    evt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (writeEn || done) evt++;
    end
    chk("no_stale_mul", evt, 0);
    cur = 103;
    acc = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = 1'b1; opcode = OP_XOR; rdVal = 8'(k * 8'h11 + 3); rsVal = 8'h5A; rdAddrIn = k[2:0];
      if (acc) dq.push_back(rdVal ^ rsVal);
      @(posedge clk); #1;
      chk("b2b_done", done, acc);
      if (done && dq.size() > 0) chk("b2b_data", data, dq.pop_front());
      acc = ~acc;
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameters: none; datapath fixed at 8 bits, register address fixed at 3 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-005 opcode  input  3  operation select (see REQ-011).
REQ-006 rdVal  input  8  first operand, value of destination register (register file rdOut).
REQ-007 rsVal  input  8  second operand (register file rsOut).
REQ-008 rdAddrIn  input  3  destination register index for writeback.
REQ-009 writeEn, dest[2:0], data[7:0]  output  register file write port; writeEn 1 bit, dest 3 bits, data 8 bits.
REQ-010 busy  output  1  high whenever state is not IDLE; done  output  1  one-cycle completion pulse; flag  output  1  status of the last completed operation.

Function
REQ-011 Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 CMP; result = rdVal op rsVal.
REQ-012 Arithmetic is modulo 256; SHL shifts rdVal left by rsVal[2:0] with zero fill; MUL yields the low byte of the unsigned 16-bit product.
REQ-013 flag: ADD carry-out; SUB borrow (rdVal < rsVal unsigned); AND/OR/XOR 0; SHL last bit shifted out (0 if shift amount 0); MUL 1 if high product byte nonzero; CMP 1 if rdVal < rsVal unsigned.
REQ-014 States: IDLE, SHIFT, MUL, WB; all outputs are registered.
REQ-015 Edge E0 = the posedge at which start=1 is sampled in IDLE; opcode, rdVal, rsVal and rdAddrIn are captured at E0 and later input changes do not affect the operation.
REQ-016 ADD/SUB/AND/OR/XOR/CMP: IDLE -> WB at E0; WB -> IDLE at E1; writeEn (except CMP) and done are high only between E0 and E1.
REQ-017 SHL with n = rsVal[2:0]: n = 0 behaves as REQ-016; otherwise IDLE -> SHIFT, one bit per cycle for n cycles, then WB, so writeEn/done are high between E(n) and E(n+1).
REQ-018 MUL: iterative shift-add, one multiplier bit per cycle; IDLE -> MUL for 8 cycles -> WB, so writeEn/done are high between E8 and E9.
REQ-019 CMP never asserts writeEn; it still passes through WB, pulses done and updates flag.
REQ-020 During the WB cycle, dest equals the captured rdAddrIn and data equals the result; in every other cycle writeEn = 0 and data/dest hold their last values.
REQ-021 flag updates only at the edge that enters WB and otherwise holds its value.
REQ-022 start is ignored while busy = 1, including in the WB cycle; the minimum start-to-start spacing is 2 cycles.
REQ-023 A start in the cycle immediately after WB (state back in IDLE) is accepted normally.

Reset
REQ-024 With reset = 1 at a posedge, state becomes IDLE and writeEn, done, busy, flag, data and dest all become 0.
REQ-025 Reset takes priority over start and over any in-flight operation; an aborted operation produces no writeEn and no done.
REQ-026 start sampled together with reset = 1 is discarded.

Structure
REQ-027 Package exec_pkg holds the opcode enum (3-bit), the state enum and the constant MUL_CYCLES = 8.
REQ-028 The iterative shift-add multiplier is a sub-module exec_mul (start, operands in; 8-bit low product and high-nonzero flag out; fixed 8-cycle latency); all other logic resides in exec_unit.

Verification
REQ-029 ADD rdVal=0xF0, rsVal=0x20, rdAddrIn=3 -> at E0+1 cycle: writeEn=1, dest=3, data=0x10, flag=1, done=1; at E1: writeEn=0, busy=0.
REQ-030 MUL rdVal=0x12, rsVal=0x10 -> busy for 9 cycles; writeEn/done between E8 and E9 with data=0x20, flag=1. MUL 0x05*0x03 -> data=0x0F, flag=0.
REQ-031 SHL rdVal=0x81, rsVal=0x03 -> writeEn between E3 and E4, data=0x08, flag=0. SHL with rsVal=0x00 -> writeEn between E0 and E1, data=0x81, flag=0.
REQ-032 CMP rdVal=0x02, rsVal=0x05 -> done pulses and flag=1, writeEn stays 0 throughout.
REQ-033 MUL started, start re-asserted with ADD at E3, reset asserted at E5 -> no writeEn and no done ever; all outputs 0 after E5; a new ADD at E6 completes normally.
REQ-034 Back-to-back start held high with XOR ops -> one op accepted every 2 cycles; changing rdVal after E0 does not change data.
